// File: rtl/ecc32_pkg.sv
// Shared constants and types for the 32-bit data / 8-check-bit SEC code.
// Used by both the encoder and the downstream corrector.
package ecc32_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CHK_W  = 8;
    localparam int unsigned CODE_W = DATA_W + CHK_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CHK_W-1:0]  chk_t;
    typedef logic [CODE_W-1:0] code_t;

    // Rows 0..3 are byte parities, rows 4..7 encode (bit-in-byte + 1) in binary,
    // so every data column is unique with weight >= 2.
    localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_MASK = {
        32'h8080_8080,
        32'h7878_7878,
        32'h6666_6666,
        32'h5555_5555,
        32'hFF00_0000,
        32'h00FF_0000,
        32'h0000_FF00,
        32'h0000_00FF
    };

    function automatic code_t make_code(input chk_t check, input data_t data);
        return {check, data};
    endfunction

endpackage

// File: rtl/ecc32_chk_gen.sv
// Combinational 32-bit data to 8-bit check-bit generator.
// Each check bit is the parity of the data bits selected by its CHK_MASK row.
module ecc32_chk_gen
    import ecc32_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CHK_W-1:0]  check
);

    always_comb begin
        check = '0;
        for (int k = 0; k < CHK_W; k++) begin
            check[k] = ^(data & CHK_MASK[k]);
        end
    end

endmodule

// File: rtl/ecc32_check_encoder.sv
// Streaming two-stage SEC encoder: 32-bit words in, {check, data} codewords out.
// Define ECC_ERR_INJECT_EN to add the one-shot codeword bit-flip ports inj_arm/inj_bit.
module ecc32_check_encoder
    import ecc32_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
`ifdef ECC_ERR_INJECT_EN
    input  logic              inj_arm,
    input  logic [5:0]        inj_bit,
`endif
    output logic [CNT_W-1:0]  word_cnt
);

    logic        s1_full;
    data_t       s1_data;
    logic        s2_full;
    code_t       s2_code;
    chk_t        s1_check;

    logic        in_fire;
    logic        out_fire;
    logic        s2_adv;
    logic        s1_move;

    ecc32_chk_gen u_chk_gen (
        .data  (s1_data),
        .check (s1_check)
    );

    // S2 can take a new word when empty or when its current word leaves this cycle.
    assign s2_adv   = !s2_full || out_ready;
    assign s1_move  = s1_full && s2_adv;
    assign in_ready = !s1_full || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_full && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_full <= 1'b0;
            s1_data <= '0;
        end else if (in_fire) begin
            s1_full <= 1'b1;
            s1_data <= in_data;
        end else if (s1_move) begin
            s1_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_full <= 1'b0;
            s2_code <= '0;
        end else if (s2_adv) begin
            s2_full <= s1_full;
            if (s1_full) begin
                s2_code <= make_code(s1_check, s1_data);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (out_fire) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    assign out_valid = s2_full;

`ifdef ECC_ERR_INJECT_EN
    logic  armed;
    code_t flip_mask;

    // A pulse during the draining cycle re-arms for the following word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (inj_arm) begin
            armed <= 1'b1;
        end else if (out_fire) begin
            armed <= 1'b0;
        end
    end

    always_comb begin
        flip_mask = '0;
        if (armed && s2_full && (int'(inj_bit) < CODE_W)) begin
            flip_mask = code_t'(1) << inj_bit;
        end
    end

    assign out_code = s2_code ^ flip_mask;
`else
    assign out_code = s2_code;
`endif

endmodule

// File: tb/tb_ecc32_check_encoder.sv
// Directed and randomized checks for ecc32_check_encoder.
// The counter is narrowed to 4 bits so wrap-around is reachable quickly.
module tb_ecc32_check_encoder;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [39:0]      out_code;
    logic [CNT_W-1:0] word_cnt;
`ifdef ECC_ERR_INJECT_EN
    logic             inj_arm;
    logic [5:0]       inj_bit;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ecc32_check_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
`ifdef ECC_ERR_INJECT_EN
        .inj_arm   (inj_arm),
        .inj_bit   (inj_bit),
`endif
        .word_cnt  (word_cnt)
    );

    // Column for data bit i: onehot(i/8) | ((i%8)+1) << 4.
    function automatic logic [39:0] ref_code(input logic [31:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) c = c ^ (8'(1 << (i / 8)) | 8'(((i % 8) + 1) << 4));
        end
        return {c, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] q[$];
    int          sent;
    int          got;
    int          guard;
    int          total_out;
    logic [31:0] exp_d;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef ECC_ERR_INJECT_EN
        inj_arm   = 1'b0;
        inj_bit   = '0;
`endif
        total_out = 0;
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_code", 64'(out_code), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // 1: single word, latency two cycles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0001;
        step();
        in_valid = 1'b0;
        chk("t1_not_yet", 64'(out_valid), 64'd0);
        step();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_code", 64'(out_code), 64'h11_0000_0001);
        step();
        chk("t1_cnt", 64'(word_cnt), 64'd1);
        chk("t1_empty", 64'(out_valid), 64'd0);
        total_out = 1;

        // 2: back-to-back words
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        step();
        in_data = 32'h8000_0000;
        step();
        in_valid = 1'b0;
        chk("t2_code_a", 64'(out_code), 64'h00_FFFF_FFFF);
        step();
        chk("t2_valid_b", 64'(out_valid), 64'd1);
        chk("t2_code_b", 64'(out_code), 64'h88_8000_0000);
        step();
        chk("t2_cnt", 64'(word_cnt), 64'd3);
        total_out = 3;

        // 3: backpressure, two words held, third refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0001;
        step();
        chk("t3_ready_1", 64'(in_ready), 64'd1);
        in_data = 32'h8000_0000;
        step();
        in_data = 32'h0000_00FF;
        chk("t3_ready_full", 64'(in_ready), 64'd0);
        chk("t3_hold_a", 64'(out_code), 64'h11_0000_0001);
        step();
        step();
        step();
        chk("t3_still_full", 64'(in_ready), 64'd0);
        chk("t3_stable_a", 64'(out_code), 64'h11_0000_0001);
        chk("t3_cnt_stall", 64'(word_cnt), 64'd3);
        out_ready = 1'b1;
        #1;
        chk("t3_ready_drain", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("t3_code_b", 64'(out_code), 64'h88_8000_0000);
        step();
        chk("t3_code_c", 64'(out_code), 64'h80_0000_00FF);
        step();
        chk("t3_empty", 64'(out_valid), 64'd0);
        chk("t3_cnt", 64'(word_cnt), 64'd6);
        total_out = 6;

        // 4: reset with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        step();
        in_data = 32'h9ABC_DEF0;
        step();
        in_valid = 1'b0;
        chk("t4_loaded", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("t4_rst_valid", 64'(out_valid), 64'd0);
        chk("t4_rst_cnt", 64'(word_cnt), 64'd0);
        chk("t4_rst_code", 64'(out_code), 64'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_no_emit", 64'(out_valid), 64'd0);
        end
        chk("t4_cnt_after", 64'(word_cnt), 64'd0);
        total_out = 0;

        // 5: random stream with random stalls against the column model
        sent  = 0;
        got   = 0;
        guard = 0;
        while ((sent < 300 || q.size() > 0) && guard < 5000) begin
            in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("t5_spurious", 64'(out_valid), 64'd0);
                end else begin
                    exp_d = q.pop_front();
                    chk("t5_code", 64'(out_code), 64'(ref_code(exp_d)));
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
            end
            step();
            guard++;
        end
        in_valid = 1'b0;
        chk("t5_all_out", 64'(got), 64'd300);
        total_out = got;
        chk("t5_cnt_wrap", 64'(word_cnt), 64'(total_out % (1 << CNT_W)));

`ifdef ECC_ERR_INJECT_EN
        // 6: one-shot bit flip on the next codeword only
        out_ready = 1'b1;
        inj_bit   = 6'd5;
        inj_arm   = 1'b1;
        step();
        inj_arm  = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h0000_0000;
        step();
        step();
        in_valid = 1'b0;
        chk("t6_flipped", 64'(out_code), 64'h00_0000_0020);
        step();
        chk("t6_clean", 64'(out_code), 64'h00_0000_0000);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
